pulse_stretch_sched: RTL and testbench

Shares one pulse-widening output channel among REQ_NUM event sources. Each requester raises a level; its rising edge is captured as a pending request. A round-robin scheduler grants the channel and drives a single pulse of that requester's configured width, followed by an enforced low gap. The block sits between the event sources (trigger, encoder, comm-status strobes) and the single downstream pulse consumer. It replaces per-source stretchers wherever the consumer accepts only one pulse at a time.

---
 rtl/pulse_stretch_sched_pkg.sv | 23 ++
 rtl/pulse_sched_rr_arb.sv | 34 +++
 rtl/pulse_stretch_sched.sv | 156 +++++++++++++++
 tb/tb_pulse_stretch_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_sched_pkg.sv
// Shared types and limits for pulse_stretch_sched: FSM states, parameter
// bounds, gap/drop counter widths and the saturating drop-count increment.
package pulse_stretch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int REQ_NUM_MIN = 2;
  localparam int REQ_NUM_MAX = 16;
  localparam int GAP_NUM_MAX = 255;
  localparam int GAP_CNT_W   = 8;
  localparam int DROP_CNT_W  = 8;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arb.sv
// Combinational round-robin pick: first pending requester at or above ptr_i,
// wrapping at REQ_NUM. Returns one-hot grant, binary index and a valid flag.
module pulse_sched_rr_arb #(
  parameter int REQ_NUM = 4,
  parameter int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] pend_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [IDX_W:0] w_pos;
  logic           w_found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      w_pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(REQ_NUM)) w_pos = w_pos - (IDX_W+1)'(REQ_NUM);
      if (!w_found && pend_i[w_pos[IDX_W-1:0]]) begin
        w_found                    = 1'b1;
        idx_o                      = w_pos[IDX_W-1:0];
        gnt_o[w_pos[IDX_W-1:0]]    = 1'b1;
      end
    end
    vld_o = w_found;
  end

endmodule

// File: rtl/pulse_stretch_sched.sv
// Round-robin shared pulse stretcher: per-requester rising edges queue a pulse
// of configured width, each followed by a fixed low gap. Optional per-requester
// saturating drop counters when PULSE_STRETCH_SCHED_DROP_CNT_EN is defined.
module pulse_stretch_sched
  import pulse_stretch_sched_pkg::*;
#(
  parameter real TCQ     = 0.1,
  parameter int  REQ_NUM = 4,
  parameter int  WIDTH_W = 16,
  parameter int  GAP_NUM = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       enable_i,
  input  logic [REQ_NUM-1:0]         evt_i,
  input  logic [REQ_NUM*WIDTH_W-1:0] cfg_width_i,
  output logic                       pulse_o,
  output logic [REQ_NUM-1:0]         owner_o,
  output logic                       busy_o,
  output logic [REQ_NUM-1:0]         drop_o
`ifdef PULSE_STRETCH_SCHED_DROP_CNT_EN
  ,
  output logic [REQ_NUM*DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int IDX_W = $clog2(REQ_NUM);

  // TCQ is a simulation-only annotation; it is range-checked but never applied here.
  if (REQ_NUM < REQ_NUM_MIN || REQ_NUM > REQ_NUM_MAX ||
      GAP_NUM < 0 || GAP_NUM > GAP_NUM_MAX || TCQ < 0.0) begin : g_bad_cfg
    $error("pulse_stretch_sched: parameter out of range");
  end

  state_e               r_state, w_state_n;
  logic [REQ_NUM-1:0]   r_evt_d, r_pend, r_owner, r_drop;
  logic [REQ_NUM-1:0]   w_pose, w_gnt, w_take_mask, w_owner_n;
  logic                 r_arm, r_pulse, w_pulse_n;
  logic [IDX_W-1:0]     r_rr_ptr, w_win_idx;
  logic                 w_win_vld, w_take;
  logic [WIDTH_W-1:0]   r_cnt, w_cnt_n, w_width;
  logic [GAP_CNT_W-1:0] r_gcnt, w_gcnt_n;

  // r_arm masks the first post-reset cycle so a level already high is not an edge.
  assign w_pose = evt_i & ~r_evt_d & {REQ_NUM{r_arm}};

  pulse_sched_rr_arb #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_arb (
    .pend_i (r_pend),
    .ptr_i  (r_rr_ptr),
    .gnt_o  (w_gnt),
    .idx_o  (w_win_idx),
    .vld_o  (w_win_vld)
  );

  assign w_width     = cfg_width_i[w_win_idx*WIDTH_W +: WIDTH_W];
  assign w_take_mask = w_take ? w_gnt : '0;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_gcnt_n  = r_gcnt;
    w_pulse_n = r_pulse;
    w_owner_n = r_owner;
    w_take    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && w_win_vld) begin
          w_take    = 1'b1;
          w_cnt_n   = (w_width == '0) ? '0 : w_width - WIDTH_W'(1);
          w_owner_n = w_gnt;
          w_pulse_n = 1'b1;
          w_state_n = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_pulse_n = 1'b0;
          w_owner_n = '0;
          if (GAP_NUM > 0) begin
            w_state_n = ST_GAP;
            w_gcnt_n  = GAP_CNT_W'(GAP_NUM > 0 ? GAP_NUM - 1 : 0);
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt - WIDTH_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gcnt == '0) w_state_n = ST_IDLE;
        else              w_gcnt_n  = r_gcnt - GAP_CNT_W'(1);
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_gcnt   <= '0;
      r_pulse  <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_gcnt  <= w_gcnt_n;
      r_pulse <= w_pulse_n;
      r_owner <= w_owner_n;
      if (w_take)
        r_rr_ptr <= (w_win_idx == IDX_W'(REQ_NUM-1)) ? '0 : w_win_idx + IDX_W'(1);
    end
  end

  // A fresh edge on the requester being granted this cycle re-queues it instead of dropping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_evt_d <= '0;
      r_arm   <= 1'b0;
      r_pend  <= '0;
      r_drop  <= '0;
    end else begin
      r_evt_d <= evt_i;
      r_arm   <= 1'b1;
      r_pend  <= (r_pend & ~w_take_mask) | w_pose;
      r_drop  <= w_pose & r_pend & ~w_take_mask;
    end
  end

  assign pulse_o = r_pulse;
  assign owner_o = r_owner;
  assign busy_o  = (r_state != ST_IDLE);
  assign drop_o  = r_drop;

`ifdef PULSE_STRETCH_SCHED_DROP_CNT_EN
  logic [REQ_NUM-1:0][DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++)
        if (r_drop[i]) r_drop_cnt[i] <= sat_inc(r_drop_cnt[i]);
    end
  end

  assign drop_cnt_o = r_drop_cnt;
`else
  // Without counters, drop_o alone reports lost edges.
`endif

endmodule

// File: tb/tb_pulse_stretch_sched.sv
// Directed bench for pulse_stretch_sched: single pulse, contention, fairness,
// drop, width-0/enable gating and reset mid-pulse, with hand-derived traces.
module tb_pulse_stretch_sched;

  localparam int N  = 4;
  localparam int WW = 16;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            en    = 1'b0;
  logic [N-1:0]    evt   = '0;
  logic [N*WW-1:0] cfg   = '0;
  logic            pulse, busy;
  logic [N-1:0]    owner, drop;
`ifdef PULSE_STRETCH_SCHED_DROP_CNT_EN
  logic [N*8-1:0]  dcnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0]  pvec, bvec;
  logic [N-1:0] own [0:31];
  logic [N-1:0] prev_own;
  logic [N-1:0] drop_at4;
  int           own2cnt, dropcnt;

  always #5 clk = ~clk;

  pulse_stretch_sched #(
    .TCQ     (0.1),
    .REQ_NUM (N),
    .WIDTH_W (WW),
    .GAP_NUM (2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .enable_i    (en),
    .evt_i       (evt),
    .cfg_width_i (cfg),
    .pulse_o     (pulse),
    .owner_o     (owner),
    .busy_o      (busy),
    .drop_o      (drop)
`ifdef PULSE_STRETCH_SCHED_DROP_CNT_EN
    ,
    .drop_cnt_o  (dcnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int i, input int w);
    cfg[i*WW +: WW] = WW'(w);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    evt   = '0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    // reset state
    tick;
    tick;
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_drop",  32'(drop),  32'd0);
    rst_n = 1'b1;
    tick;

    // single event, width 5
    en = 1'b1;
    set_w(1, 5);
    evt[1] = 1'b1;
    pvec = '0; bvec = '0;
    for (int c = 0; c < 12; c++) begin
      tick;
      pvec[c] = pulse;
      bvec[c] = busy;
      if (c == 3) chk("t1_owner", 32'(owner), 32'h2);
      if (c == 6) chk("t1_owner_off", 32'(owner), 32'h0);
    end
    chk("t1_pulse", pvec, 32'h03E);
    chk("t1_busy",  bvec, 32'h0FE);

    // contention: all four at once, width 3
    do_reset;
    for (int i = 0; i < N; i++) set_w(i, 3);
    evt = 4'hF;
    pvec = '0;
    for (int c = 0; c < 24; c++) begin
      tick;
      pvec[c] = pulse;
      own[c]  = owner;
    end
    chk("t2_pulse", pvec, 32'h0038E38E);
    chk("t2_own0",  32'(own[2]),  32'h1);
    chk("t2_own1",  32'(own[8]),  32'h2);
    chk("t2_own2",  32'(own[14]), 32'h4);
    chk("t2_own3",  32'(own[20]), 32'h8);
    chk("t2_gap_owner", 32'(own[4]), 32'h0);

    // fairness: 0 and 2 re-pulse right after each grant
    do_reset;
    evt = 4'b0101;
    prev_own = '0;
    for (int c = 0; c < 24; c++) begin
      tick;
      own[c] = owner;
      for (int i = 0; i < N; i += 2)
        evt[i] = !(owner[i] && !prev_own[i]);
      prev_own = owner;
    end
    chk("t3_g0", 32'(own[2]),  32'h1);
    chk("t3_g1", 32'(own[8]),  32'h4);
    chk("t3_g2", 32'(own[14]), 32'h1);
    chk("t3_g3", 32'(own[20]), 32'h4);

    // drop: req 2 edges twice while req 0 holds an 8-cycle pulse
    do_reset;
    set_w(0, 8);
    set_w(2, 3);
    evt = 4'b0001;
    pvec = '0; own2cnt = 0; dropcnt = 0; drop_at4 = '0;
    for (int c = 0; c < 26; c++) begin
      tick;
      pvec[c] = pulse;
      own[c]  = owner;
      if (owner == 4'b0100) own2cnt++;
      if (drop[2]) dropcnt++;
      if (c == 4) drop_at4 = drop;
      if (c == 1) evt[2] = 1'b1;
      if (c == 2) evt[2] = 1'b0;
      if (c == 3) evt[2] = 1'b1;
    end
    chk("t4_drop_at4",  32'(drop_at4), 32'h4);
    chk("t4_drop_cnt",  32'(dropcnt),  32'd1);
    chk("t4_own2_cyc",  32'(own2cnt),  32'd3);
    chk("t4_own2_at12", 32'(own[12]),  32'h4);
    chk("t4_pulse",     pvec,          32'h000071FE);
`ifdef PULSE_STRETCH_SCHED_DROP_CNT_EN
    chk("t4_dcnt2", 32'(dcnt[23:16]), 32'd1);
`endif

    // width 0 and enable gating
    do_reset;
    en = 1'b0;
    set_w(1, 0);
    set_w(3, 2);
    evt = 4'b1010;
    pvec = '0; bvec = '0;
    for (int c = 0; c < 14; c++) begin
      tick;
      pvec[c] = pulse;
      bvec[c] = busy;
      own[c]  = owner;
      if (c == 5) en = 1'b1;
    end
    chk("t5_pulse", pvec, 32'h00000C40);
    chk("t5_busy",  bvec, 32'h00003DC0);
    chk("t5_own1",  32'(own[6]),  32'h2);
    chk("t5_own3",  32'(own[10]), 32'h8);

    // reset during an 8-cycle pulse, evt held high across release
    do_reset;
    en = 1'b1;
    set_w(0, 8);
    evt = 4'b0001;
    pvec = '0; bvec = '0;
    for (int c = 0; c < 16; c++) begin
      tick;
      pvec[c] = pulse;
      bvec[c] = busy;
      own[c]  = owner;
      if (c == 3) rst_n = 1'b0;
      if (c == 5) rst_n = 1'b1;
    end
    chk("t6_pulse",     pvec, 32'h0000000E);
    chk("t6_busy",      bvec, 32'h0000000E);
    chk("t6_owner_rst", 32'(own[4]), 32'h0);
    chk("t6_owner_mid", 32'(own[2]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
